// File: rtl/gpio_pixel_packer_if.sv
// gpio_pixel_packer_if: GPIO store-port inputs and RGB pixel stream of gpio_pixel_packer.
//   gpio/gpio_en_r/g/b/gpio_en : sample word, per-channel strobes, frame-end marker
//   pix_valid/pix_ready/pix_data/pix_last : pixel stream, pix_data = {R, G, B}
//   busy/overflow : emitting status, sticky drop flag
//   master = producer/sink side, slave = packer side
interface gpio_pixel_packer_if #(
    parameter int W        = 128,
    parameter int SAMPLE_W = 8
);
    logic [W-1:0]          gpio;
    logic                  gpio_en_r;
    logic                  gpio_en_g;
    logic                  gpio_en_b;
    logic                  gpio_en;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [3*SAMPLE_W-1:0] pix_data;
    logic                  pix_last;
    logic                  busy;
    logic                  overflow;
    modport master (
        output gpio, gpio_en_r, gpio_en_g, gpio_en_b, gpio_en, pix_ready,
        input  pix_valid, pix_data, pix_last, busy, overflow
    );
    modport slave (
        input  gpio, gpio_en_r, gpio_en_g, gpio_en_b, gpio_en, pix_ready,
        output pix_valid, pix_data, pix_last, busy, overflow
    );
endinterface

// File: rtl/gpio_pixel_packer.sv
// gpio_pixel_packer: collects R, G, B GPIO words and emits LANES packed {R,G,B} pixels on a valid/ready stream.
//   clk, rst : clock, synchronous active-high reset
//   io_bus   : gpio_pixel_packer_if.slave (GPIO strobes in, pixel stream and status out)
//   GPIO_PIXEL_PACKER_DBUF_EN : adds a shadow bank so groups can be collected while emitting
module gpio_pixel_packer #(
    parameter int LANES    = 16,
    parameter int SAMPLE_W = 8
) (
    input logic                clk,
    input logic                rst,
    gpio_pixel_packer_if.slave io_bus
);
    localparam int W  = LANES * SAMPLE_W;
    localparam int IW = $clog2(LANES);
    localparam logic [IW-1:0] LAST = IW'(LANES - 1);
    typedef enum logic {COLLECT, EMIT} state_t;
    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_idx;
    logic          r_overflow;
    logic [2:0]    w_stb;
    logic          w_hs, w_fin, w_wr, w_drop, w_done, w_elp;
    logic [W-1:0]  w_er, w_eg, w_eb;
    assign w_stb = {io_bus.gpio_en_b, io_bus.gpio_en_g, io_bus.gpio_en_r};
    assign w_hs  = (r_state == EMIT) && io_bus.pix_ready;
    assign w_fin = w_hs && (r_idx == LAST);
`ifdef GPIO_PIXEL_PACKER_DBUF_EN
    // r_act is the bank being collected in COLLECT or emitted in EMIT; ~r_act is the shadow
    logic [W-1:0] r_r [2];
    logic [W-1:0] r_g [2];
    logic [W-1:0] r_b [2];
    logic [2:0]   r_have [2];
    logic [2:0]   w_have_nxt [2];
    logic [1:0]   r_lp, w_lp_nxt;
    logic         r_act, w_act_nxt, w_swap, w_wb;
    always_comb begin
        w_swap    = w_fin && (&r_have[~r_act]);
        // after a swap the old emitting bank is the one collecting, so same-cycle strobes go there
        w_wb      = (r_state == COLLECT || w_swap) ? r_act : ~r_act;
        w_drop    = (r_state == EMIT) && !w_swap && (&r_have[~r_act]) && (|w_stb);
        w_wr      = !w_drop;
        w_act_nxt = w_fin ? ~r_act : r_act;
        for (int k = 0; k < 2; k++) begin
            w_have_nxt[k] = ((w_fin && 1'(k) == r_act) ? 3'b000 : r_have[k])
                          | ((w_wr && 1'(k) == w_wb) ? w_stb : 3'b000);
            w_lp_nxt[k]   = (!(w_fin && 1'(k) == r_act) && r_lp[k])
                          || (1'(k) == w_wb && io_bus.gpio_en);
        end
        w_done = &w_have_nxt[w_act_nxt];
        w_er   = r_r[r_act];
        w_eg   = r_g[r_act];
        w_eb   = r_b[r_act];
        w_elp  = r_lp[r_act];
    end
    always_ff @(posedge clk) begin
        r_act <= rst ? 1'b0 : w_act_nxt;
        r_lp  <= rst ? 2'b00 : w_lp_nxt;
        for (int k = 0; k < 2; k++) r_have[k] <= rst ? 3'b000 : w_have_nxt[k];
        if (w_wr && w_stb[0]) r_r[w_wb] <= io_bus.gpio;
        if (w_wr && w_stb[1]) r_g[w_wb] <= io_bus.gpio;
        if (w_wr && w_stb[2]) r_b[w_wb] <= io_bus.gpio;
    end
`else
    logic [W-1:0] r_r, r_g, r_b;
    logic [2:0]   r_have, w_have_nxt;
    logic         r_lp, w_lp_nxt;
    always_comb begin
        w_wr       = (r_state == COLLECT);
        w_drop     = (r_state == EMIT) && ((|w_stb) || io_bus.gpio_en);
        w_have_nxt = (w_fin ? 3'b000 : r_have) | (w_wr ? w_stb : 3'b000);
        w_lp_nxt   = (!w_fin && r_lp) || (w_wr && io_bus.gpio_en);
        w_done     = &w_have_nxt;
        w_er       = r_r;
        w_eg       = r_g;
        w_eb       = r_b;
        w_elp      = r_lp;
    end
    always_ff @(posedge clk) begin
        r_have <= rst ? 3'b000 : w_have_nxt;
        r_lp   <= rst ? 1'b0 : w_lp_nxt;
        if (w_wr && w_stb[0]) r_r <= io_bus.gpio;
        if (w_wr && w_stb[1]) r_g <= io_bus.gpio;
        if (w_wr && w_stb[2]) r_b <= io_bus.gpio;
    end
`endif
    // stay in EMIT until the last pixel; then (re)enter EMIT only if the next collecting bank is full
    always_comb begin
        w_state_nxt = ((r_state == EMIT && !w_fin) || w_done) ? EMIT : COLLECT;
    end
    always_ff @(posedge clk) begin
        r_state    <= rst ? COLLECT : w_state_nxt;
        r_idx      <= rst ? '0 : (w_hs ? r_idx + 1'b1 : r_idx);
        r_overflow <= !rst && (r_overflow || w_drop);
    end
    assign io_bus.pix_valid = (r_state == EMIT);
    assign io_bus.busy      = (r_state == EMIT);
    assign io_bus.overflow  = r_overflow;
    assign io_bus.pix_last  = (r_state == EMIT) && w_elp && (r_idx == LAST);
    assign io_bus.pix_data  = (r_state == EMIT)
        ? {w_er[r_idx*SAMPLE_W +: SAMPLE_W], w_eg[r_idx*SAMPLE_W +: SAMPLE_W], w_eb[r_idx*SAMPLE_W +: SAMPLE_W]}
        : '0;
endmodule

// File: tb/tb_gpio_pixel_packer.sv
// tb_gpio_pixel_packer: directed self-checking bench for gpio_pixel_packer.
module tb_gpio_pixel_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    gpio_pixel_packer_if bus ();
    gpio_pixel_packer dut (.clk(clk), .rst(rst), .io_bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [127:0] ramp(input logic [7:0] b);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = b + 8'(i);
        return r;
    endfunction
    function automatic logic [23:0] pix(input logic [127:0] r, input logic [127:0] g, input logic [127:0] b, input int i);
        return {r[i*8 +: 8], g[i*8 +: 8], b[i*8 +: 8]};
    endfunction
    task automatic strobe(input logic [2:0] s, input logic e, input logic [127:0] d);
        bus.gpio = d;
        {bus.gpio_en_b, bus.gpio_en_g, bus.gpio_en_r} = s;
        bus.gpio_en = e;
        tick;
        {bus.gpio_en_b, bus.gpio_en_g, bus.gpio_en_r} = 3'b000;
        bus.gpio_en = 1'b0;
    endtask
    // observes a group from its current pixel; bp applies the ready pattern 1,0,0,1
    task automatic run_group(input logic [127:0] er, input logic [127:0] eg, input logic [127:0] eb,
                             input logic lp, input logic bp, input string tag);
        int   idx = 0;
        int   cyc = 0;
        logic rdy;
        logic [3:0] pat = 4'b1001;
        while (idx < 16 && cyc < 100) begin
            check({tag, "_valid"}, 32'(bus.pix_valid), 32'd1);
            check({tag, "_data"}, 32'(bus.pix_data), 32'(pix(er, eg, eb, idx)));
            check({tag, "_last"}, 32'(bus.pix_last), 32'(lp && idx == 15));
            rdy = bp ? pat[cyc % 4] : 1'b1;
            bus.pix_ready = rdy;
            tick;
            if (rdy) idx++;
            cyc++;
        end
        bus.pix_ready = 1'b1;
        check({tag, "_handshakes"}, 32'(idx), 32'd16);
        check({tag, "_done"}, 32'(bus.pix_valid), 32'd0);
    endtask
    initial begin
        bus.gpio = '0;
        {bus.gpio_en_b, bus.gpio_en_g, bus.gpio_en_r} = 3'b000;
        bus.gpio_en = 1'b0;
        bus.pix_ready = 1'b1;
        repeat (3) tick;
        check("rst_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_data", 32'(bus.pix_data), 32'd0);
        check("rst_last", 32'(bus.pix_last), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        tick;
        strobe(3'b001, 1'b0, ramp(8'h00));
        strobe(3'b010, 1'b0, ramp(8'h10));
        check("basic_wait", 32'(bus.busy), 32'd0);
        strobe(3'b100, 1'b0, ramp(8'h20));
        for (int i = 0; i < 16; i++) begin
            check("basic_valid", 32'(bus.pix_valid), 32'd1);
            check("basic_data", 32'(bus.pix_data), {8'h00, 8'(i), 8'(16 + i), 8'(32 + i)});
            check("basic_last", 32'(bus.pix_last), 32'd0);
            tick;
        end
        check("basic_collect", 32'(bus.busy), 32'd0);
        strobe(3'b111, 1'b1, {16{8'hAA}});
        run_group({16{8'hAA}}, {16{8'hAA}}, {16{8'hAA}}, 1'b1, 1'b0, "simul");
        strobe(3'b001, 1'b0, {16{8'h11}});
        strobe(3'b001, 1'b0, {16{8'h22}});
        strobe(3'b010, 1'b0, {16{8'h33}});
        strobe(3'b100, 1'b0, {16{8'h44}});
        check("ovw_first", 32'(bus.pix_data), 32'h223344);
        run_group({16{8'h22}}, {16{8'h33}}, {16{8'h44}}, 1'b0, 1'b0, "ovw");
        check("ovw_ovf", 32'(bus.overflow), 32'd0);
        strobe(3'b001, 1'b0, ramp(8'h00));
        strobe(3'b010, 1'b0, ramp(8'h10));
        strobe(3'b100, 1'b0, ramp(8'h20));
        run_group(ramp(8'h00), ramp(8'h10), ramp(8'h20), 1'b0, 1'b1, "bp");
`ifdef GPIO_PIXEL_PACKER_DBUF_EN
        strobe(3'b001, 1'b0, ramp(8'h00));
        strobe(3'b010, 1'b0, ramp(8'h10));
        strobe(3'b100, 1'b0, ramp(8'h20));
        for (int c = 0; c < 32; c++) begin
            check("dbuf_valid", 32'(bus.pix_valid), 32'd1);
            check("dbuf_data", 32'(bus.pix_data),
                  c < 16 ? 32'(pix(ramp(8'h00), ramp(8'h10), ramp(8'h20), c))
                         : 32'(pix(ramp(8'h80), ramp(8'h90), ramp(8'hA0), c - 16)));
            bus.gpio = c == 0 ? ramp(8'h80) : c == 1 ? ramp(8'h90) : ramp(8'hA0);
            {bus.gpio_en_b, bus.gpio_en_g, bus.gpio_en_r} = c == 0 ? 3'b001 : c == 1 ? 3'b010 : c == 2 ? 3'b100 : 3'b000;
            tick;
            {bus.gpio_en_b, bus.gpio_en_g, bus.gpio_en_r} = 3'b000;
        end
        check("dbuf_done", 32'(bus.pix_valid), 32'd0);
        check("dbuf_ovf", 32'(bus.overflow), 32'd0);
`else
        strobe(3'b001, 1'b0, ramp(8'h00));
        strobe(3'b010, 1'b0, ramp(8'h10));
        strobe(3'b100, 1'b0, ramp(8'h20));
        check("drop_ovf_pre", 32'(bus.overflow), 32'd0);
        check("drop_p0", 32'(bus.pix_data), 32'h001020);
        strobe(3'b001, 1'b0, {16{8'hFF}});
        check("drop_ovf", 32'(bus.overflow), 32'd1);
        for (int i = 1; i < 16; i++) begin
            check("drop_data", 32'(bus.pix_data), {8'h00, 8'(i), 8'(16 + i), 8'(32 + i)});
            tick;
        end
        check("drop_done", 32'(bus.pix_valid), 32'd0);
        strobe(3'b010, 1'b0, ramp(8'h50));
        strobe(3'b100, 1'b0, ramp(8'h60));
        check("drop_need_r", 32'(bus.busy), 32'd0);
        strobe(3'b001, 1'b0, ramp(8'h70));
        check("drop_next_p0", 32'(bus.pix_data), 32'h705060);
        run_group(ramp(8'h70), ramp(8'h50), ramp(8'h60), 1'b0, 1'b0, "drop_next");
        check("drop_ovf_sticky", 32'(bus.overflow), 32'd1);
`endif
        strobe(3'b001, 1'b0, ramp(8'h40));
        strobe(3'b010, 1'b0, ramp(8'h50));
        strobe(3'b100, 1'b0, ramp(8'h60));
        repeat (5) tick;
        check("mid_p5", 32'(bus.pix_data), 32'h455565);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mid_valid", 32'(bus.pix_valid), 32'd0);
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_ovf", 32'(bus.overflow), 32'd0);
        check("mid_data", 32'(bus.pix_data), 32'd0);
        tick;
        check("mid_idle", 32'(bus.pix_valid), 32'd0);
        strobe(3'b001, 1'b0, ramp(8'h03));
        strobe(3'b010, 1'b0, ramp(8'h13));
        strobe(3'b100, 1'b0, ramp(8'h23));
        run_group(ramp(8'h03), ramp(8'h13), ramp(8'h23), 1'b0, 1'b0, "after_rst");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
